// File: rtl/rename_unit.sv
// rename_unit: N-wide register rename with speculative/committed RAT and free-list bitmap
module rename_unit #(
    parameter int WIDTH     = 2,
    parameter int NUM_PREGS = 64,
    parameter int PREG_W    = $clog2(NUM_PREGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_lane_valid,
    input  logic [WIDTH*5-1:0]        in_rs1,
    input  logic [WIDTH*5-1:0]        in_rs2,
    input  logic [WIDTH*5-1:0]        in_rd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_lane_valid,
    output logic [WIDTH*PREG_W-1:0]   out_prs1,
    output logic [WIDTH*PREG_W-1:0]   out_prs2,
    output logic [WIDTH*PREG_W-1:0]   out_prd,
    output logic [WIDTH*PREG_W-1:0]   out_old_prd,
    input  logic [WIDTH-1:0]          commit_valid,
    input  logic [WIDTH*5-1:0]        commit_rd,
    input  logic [WIDTH*PREG_W-1:0]   commit_prd,
    input  logic [WIDTH*PREG_W-1:0]   commit_old_prd,
    input  logic                      flush,
    output logic [PREG_W:0]           free_count
);
    logic [PREG_W-1:0]               spec_rat [32];
    logic [PREG_W-1:0]               arch_rat [32];
    logic [PREG_W-1:0]               spec_nxt [32];
    logic [PREG_W-1:0]               arch_nxt [32];
    logic [NUM_PREGS-1:0]            free_list, free_nxt, avail, alloc_mask, freed, held;
    logic [WIDTH-1:0]                need_lane;
    logic [PREG_W:0]                 need, cnt_nxt;
    logic [WIDTH-1:0][PREG_W-1:0]    alloc, prs1, prs2, old_prd;
    logic                            accept;

    assign in_ready = !flush && (!out_valid || out_ready) && (free_count >= need);
    assign accept   = in_valid && in_ready;

    // Hand the lowest free tags to lanes writing a nonzero rd, oldest lane first
    always_comb begin
        avail = free_list;
        alloc_mask = '0;
        need = '0;
        for (int i = 0; i < WIDTH; i++) begin
            need_lane[i] = in_lane_valid[i] && (in_rd[5*i +: 5] != 5'd0);
            alloc[i] = '0;
            if (need_lane[i]) begin
                need = need + (PREG_W+1)'(1);
                for (int p = NUM_PREGS - 1; p > 0; p--)
                    if (avail[p]) alloc[i] = PREG_W'(p);
                avail[alloc[i]] = 1'b0;
                alloc_mask[alloc[i]] = 1'b1;
            end
        end
        alloc_mask[0] = 1'b0;
    end

    // Look up sources and old destinations, bypassing from older lanes in the same group
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            prs1[i] = spec_rat[in_rs1[5*i +: 5]];
            prs2[i] = spec_rat[in_rs2[5*i +: 5]];
            old_prd[i] = need_lane[i] ? spec_rat[in_rd[5*i +: 5]] : '0;
            for (int j = 0; j < i; j++) begin
                if (need_lane[j] && in_rd[5*j +: 5] == in_rs1[5*i +: 5]) prs1[i] = alloc[j];
                if (need_lane[j] && in_rd[5*j +: 5] == in_rs2[5*i +: 5]) prs2[i] = alloc[j];
                if (need_lane[i] && need_lane[j] && in_rd[5*j +: 5] == in_rd[5*i +: 5]) old_prd[i] = alloc[j];
            end
        end
    end

    // Next RAT and free-list contents: commits first, then flush recovery or group allocation
    always_comb begin
        arch_nxt = arch_rat;
        freed = '0;
        for (int k = 0; k < WIDTH; k++)
            if (commit_valid[k] && commit_rd[5*k +: 5] != 5'd0) begin
                arch_nxt[commit_rd[5*k +: 5]] = commit_prd[PREG_W*k +: PREG_W];
                freed[commit_old_prd[PREG_W*k +: PREG_W]] = 1'b1;
            end
        held = '0;
        for (int r = 0; r < 32; r++)
            held[arch_nxt[r]] = 1'b1;
        spec_nxt = spec_rat;
        if (flush)
            spec_nxt = arch_nxt;
        else if (accept)
            for (int i = 0; i < WIDTH; i++)
                if (need_lane[i]) spec_nxt[in_rd[5*i +: 5]] = alloc[i];
        free_nxt = flush ? ~held : (free_list & ~(accept ? alloc_mask : '0)) | freed;
        free_nxt[0] = 1'b0;
        cnt_nxt = '0;
        for (int p = 0; p < NUM_PREGS; p++)
            cnt_nxt = cnt_nxt + (PREG_W+1)'(free_nxt[p]);
    end

    // Rename tables, free list and its population count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                spec_rat[r] <= PREG_W'(r);
                arch_rat[r] <= PREG_W'(r);
            end
            for (int p = 0; p < NUM_PREGS; p++)
                free_list[p] <= (p >= 32);
            free_count <= (PREG_W+1)'(NUM_PREGS - 32);
        end else begin
            spec_rat <= spec_nxt;
            arch_rat <= arch_nxt;
            free_list <= free_nxt;
            free_count <= cnt_nxt;
        end
    end

    // Output register: flush drops it, accept reloads it, out_ready drains it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_lane_valid <= '0;
            out_prs1 <= '0;
            out_prs2 <= '0;
            out_prd <= '0;
            out_old_prd <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_lane_valid <= in_lane_valid;
            out_prs1 <= prs1;
            out_prs2 <= prs2;
            out_prd <= alloc;
            out_old_prd <= old_prd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: directed and randomized checks of rename_unit against a sequential rename model
module tb_rename_unit;
    localparam int W  = 2;
    localparam int NP = 64;
    localparam int PW = $clog2(NP);

    logic          clk = 0, rst_n = 0;
    logic          in_valid = 0, in_ready;
    logic [W-1:0]  in_lane_valid = '0;
    logic [W*5-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic          out_valid, out_ready = 0;
    logic [W-1:0]  out_lane_valid;
    logic [W*PW-1:0] out_prs1, out_prs2, out_prd, out_old_prd;
    logic [W-1:0]  commit_valid = '0;
    logic [W*5-1:0] commit_rd = '0;
    logic [W*PW-1:0] commit_prd = '0, commit_old_prd = '0;
    logic          flush = 0;
    logic [PW:0]   free_count;

    int checks = 0, errors = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;

    rename_unit #(.WIDTH(W), .NUM_PREGS(NP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
        .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd), .out_old_prd(out_old_prd),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_prd(commit_prd),
        .commit_old_prd(commit_old_prd), .flush(flush), .free_count(free_count)
    );

    // Reference state: plain tables updated one instruction at a time
    int  m_spec[32], m_arch[32];
    bit  m_free[NP];
    bit  m_ov;
    bit [W-1:0] m_olv;
    int  m_prs1[W], m_prs2[W], m_prd[W], m_old[W];
    typedef struct { int rd; int prd; int old; } ent_t;
    ent_t inflight[$];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int f5(logic [W*5-1:0] v, int i);
        return int'(v[5*i +: 5]);
    endfunction

    function automatic int fp(logic [W*PW-1:0] v, int i);
        return int'(v[PW*i +: PW]);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int p = 0; p < NP; p++) c += int'(m_free[p]);
        return c;
    endfunction

    function automatic int m_need();
        int n = 0;
        for (int i = 0; i < W; i++) if (in_lane_valid[i] && f5(in_rd, i) != 0) n++;
        return n;
    endfunction

    function automatic bit m_ready();
        return !flush && (!m_ov || out_ready) && m_count() >= m_need();
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin m_spec[r] = r; m_arch[r] = r; end
        for (int p = 0; p < NP; p++) m_free[p] = (p >= 32);
        m_ov = 0;
        m_olv = '0;
        for (int i = 0; i < W; i++) begin m_prs1[i] = 0; m_prs2[i] = 0; m_prd[i] = 0; m_old[i] = 0; end
        inflight.delete();
    endtask

    task automatic model_step();
        int  arch_post[32];
        bit  fr[NP];
        bit  acc;
        acc = in_valid && m_ready();
        arch_post = m_arch;
        fr = m_free;
        for (int k = 0; k < W; k++)
            if (commit_valid[k] && f5(commit_rd, k) != 0) arch_post[f5(commit_rd, k)] = fp(commit_prd, k);
        if (flush) begin
            for (int p = 0; p < NP; p++) fr[p] = 1;
            for (int r = 0; r < 32; r++) fr[arch_post[r]] = 0;
            fr[0] = 0;
            m_spec = arch_post;
            m_ov = 0;
            inflight.delete();
        end else begin
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    int rd;
                    rd = f5(in_rd, i);
                    m_prs1[i] = m_spec[f5(in_rs1, i)];
                    m_prs2[i] = m_spec[f5(in_rs2, i)];
                    m_prd[i] = 0;
                    m_old[i] = 0;
                    if (in_lane_valid[i] && rd != 0) begin
                        int np;
                        np = 0;
                        for (int p = NP - 1; p >= 1; p--) if (fr[p]) np = p;
                        fr[np] = 0;
                        m_old[i] = m_spec[rd];
                        m_prd[i] = np;
                        m_spec[rd] = np;
                        inflight.push_back('{rd, np, m_old[i]});
                    end
                end
                m_olv = in_lane_valid;
                m_ov = 1;
            end else if (out_ready) m_ov = 0;
            for (int k = 0; k < W; k++)
                if (commit_valid[k] && f5(commit_rd, k) != 0) fr[fp(commit_old_prd, k)] = 1;
            fr[0] = 0;
        end
        m_free = fr;
        m_arch = arch_post;
    endtask

    // Cycle-by-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("out_valid", out_valid, m_ov);
            chk("free_count", free_count, m_count());
            chk("in_ready", in_ready, m_ready());
            if (m_ov) begin
                chk("out_lane_valid", out_lane_valid, m_olv);
                for (int i = 0; i < W; i++) begin
                    chk($sformatf("prs1[%0d]", i), fp(out_prs1, i), m_prs1[i]);
                    chk($sformatf("prs2[%0d]", i), fp(out_prs2, i), m_prs2[i]);
                    chk($sformatf("prd[%0d]", i), fp(out_prd, i), m_prd[i]);
                    chk($sformatf("old_prd[%0d]", i), fp(out_old_prd, i), m_old[i]);
                end
            end
        end
    end

    task automatic drive_idle();
        in_valid = 0; in_lane_valid = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        commit_valid = '0; commit_rd = '0; commit_prd = '0; commit_old_prd = '0; flush = 0;
    endtask

    task automatic set_lane(int i, bit v, int rs1, int rs2, int rd);
        in_lane_valid[i] = v;
        in_rs1[5*i +: 5] = 5'(rs1);
        in_rs2[5*i +: 5] = 5'(rs2);
        in_rd[5*i +: 5] = 5'(rd);
    endtask

    task automatic set_commit(int k, int rd, int prd, int old);
        commit_valid[k] = 1;
        commit_rd[5*k +: 5] = 5'(rd);
        commit_prd[PW*k +: PW] = PW'(prd);
        commit_old_prd[PW*k +: PW] = PW'(old);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #2;
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        drive_idle();
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        do_reset();
        cmp_en = 1;
        out_ready = 1;
        chk("rst free_count", free_count, 32);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_prd", out_prd, 0);

        // Two independent destinations right after reset
        set_lane(0, 1, 0, 0, 5); set_lane(1, 1, 0, 0, 6); in_valid = 1;
        #1 chk("g1 in_ready", in_ready, 1);
        step(); drive_idle();
        chk("g1 out_valid", out_valid, 1);
        chk("g1 prd0", fp(out_prd, 0), 32);
        chk("g1 prd1", fp(out_prd, 1), 33);
        chk("g1 old0", fp(out_old_prd, 0), 5);
        chk("g1 old1", fp(out_old_prd, 1), 6);
        chk("g1 free_count", free_count, 30);

        // Intra-group bypass on sources and old destination
        do_reset(); out_ready = 1;
        set_lane(0, 1, 0, 0, 3); set_lane(1, 1, 3, 3, 3); in_valid = 1;
        step(); drive_idle();
        chk("byp prs1", fp(out_prs1, 1), 32);
        chk("byp prs2", fp(out_prs2, 1), 32);
        chk("byp prd1", fp(out_prd, 1), 33);
        chk("byp old1", fp(out_old_prd, 1), 32);
        set_lane(0, 1, 3, 0, 0); in_valid = 1;
        step(); drive_idle();
        chk("spec_rat[3]", fp(out_prs1, 0), 33);

        // Output stall, then replacement with no bubble, then async reset mid-stall
        do_reset(); out_ready = 0;
        set_lane(0, 1, 0, 0, 1); set_lane(1, 1, 0, 0, 2); in_valid = 1;
        step();
        set_lane(0, 1, 0, 0, 3); set_lane(1, 1, 0, 0, 4);
        for (int c = 0; c < 3; c++) begin
            #1 chk("stall in_ready", in_ready, 0);
            step();
            chk("stall prd0", fp(out_prd, 0), 32);
            chk("stall prd1", fp(out_prd, 1), 33);
            chk("stall valid", out_valid, 1);
        end
        out_ready = 1;
        #1 chk("release in_ready", in_ready, 1);
        step();
        chk("nobubble valid", out_valid, 1);
        chk("nobubble prd0", fp(out_prd, 0), 34);
        chk("nobubble prd1", fp(out_prd, 1), 35);
        out_ready = 0; set_lane(0, 1, 0, 0, 7);
        step();
        rst_n = 0;
        #1;
        chk("async out_valid", out_valid, 0);
        chk("async free_count", free_count, 32);
        model_reset(); drive_idle();
        step(); step(); rst_n = 1;
        out_ready = 1;
        set_lane(0, 1, 0, 0, 0); set_lane(1, 1, 0, 0, 0); in_valid = 1;
        step(); drive_idle();
        chk("x0 free_count", free_count, 32);
        chk("x0 prd", out_prd, 0);
        chk("x0 old", out_old_prd, 0);

        // Exhaust the free list, then free one tag by commit
        do_reset(); out_ready = 1;
        set_lane(0, 1, 0, 0, 1); set_lane(1, 1, 0, 0, 2); in_valid = 1;
        step();
        for (int g = 0; g < 14; g++) begin
            set_lane(0, 1, 0, 0, $urandom_range(1, 31)); set_lane(1, 1, 0, 0, $urandom_range(1, 31));
            step();
        end
        set_lane(1, 0, 0, 0, 0);
        step(); drive_idle();
        chk("exh free_count", free_count, 1);
        set_lane(0, 1, 0, 0, 8); set_lane(1, 1, 0, 0, 9); in_valid = 1;
        #1 chk("exh in_ready", in_ready, 0);
        set_commit(0, 1, 32, 1);
        #1 chk("exh commit-cycle in_ready", in_ready, 0);
        step();
        commit_valid = '0;
        #1 chk("exh freed in_ready", in_ready, 1);
        step(); drive_idle();
        chk("exh prd0", fp(out_prd, 0), 1);
        chk("exh prd1", fp(out_prd, 1), 63);
        chk("exh empty", free_count, 0);

        // Commit the older of two x5 renames while flushing
        do_reset(); out_ready = 1;
        set_lane(0, 1, 0, 0, 5); in_valid = 1;
        step();
        step(); drive_idle();
        chk("fl old", fp(out_old_prd, 0), 32);
        set_commit(0, 5, 32, 5); flush = 1;
        step(); drive_idle();
        chk("fl out_valid", out_valid, 0);
        set_lane(0, 1, 5, 0, 7); in_valid = 1;
        #1 chk("fl in_ready", in_ready, 1);
        step(); drive_idle();
        chk("fl spec_rat[5]", fp(out_prs1, 0), 32);
        chk("fl prd reuses 5", fp(out_prd, 0), 5);
        chk("fl old7", fp(out_old_prd, 0), 7);

        // Random traffic with in-order commits and occasional flushes
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int n;
            drive_idle();
            out_ready = $urandom_range(0, 3) != 0;
            in_valid = $urandom_range(0, 2) != 0;
            for (int i = 0; i < W; i++)
                set_lane(i, $urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31));
            flush = $urandom_range(0, 40) == 0;
            n = $urandom_range(0, W);
            for (int k = 0; k < n; k++)
                if (inflight.size() > 0) begin
                    ent_t e;
                    e = inflight.pop_front();
                    set_commit(k, e.rd, e.prd, e.old);
                end
            step();
        end
        drive_idle();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
